// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the 32-bit MIPS-subset datapath. It steps one instruction
// through FETCH/DECODE/EXEC/MEM/WB states and times out on a data-memory handshake that never completes.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic [1:0]       PCSrc,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrc,
    output logic             RegA,
    output logic             RegB,
    output logic [3:0]       ALUOp,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic [3:0]       State,
    output logic             Illegal,
    output logic             Fault,
    output logic [CNT_W-1:0] RetireCount
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_FAULT    = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // One extra bit so the counter can step past the last legal value on the fault edge.
    localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [3:0]        state;
    logic [3:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire;

    logic       is_r, is_lw, is_sw, is_beq, is_addi, is_j;
    logic       r_ok, is_shift;
    logic [3:0] alu_r;

    assign is_r    = (op == OP_RTYPE);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_addi = (op == OP_ADDI);
    assign is_j    = (op == OP_J);

    always_comb begin
        alu_r    = 4'b0000;
        r_ok     = 1'b1;
        is_shift = 1'b0;
        case (func)
            6'b100000: alu_r = 4'b0000;
            6'b100010: alu_r = 4'b0001;
            6'b100100: alu_r = 4'b0010;
            6'b100101: alu_r = 4'b0011;
            6'b101010: alu_r = 4'b0100;
            6'b000000: begin alu_r = 4'b1000; is_shift = 1'b1; end
            6'b000010: begin alu_r = 4'b1001; is_shift = 1'b1; end
            default:   r_ok = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        retire    = 1'b0;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_r && r_ok)         state_nxt = S_EXEC_R;
                else if (is_addi)         state_nxt = S_EXEC_I;
                else if (is_lw || is_sw)  state_nxt = S_MEM_ADDR;
                else if (is_beq)          state_nxt = S_BRANCH;
                else if (is_j)            state_nxt = S_JUMP;
                else                      state_nxt = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: state_nxt = S_WB_ALU;
            S_MEM_ADDR: state_nxt = is_lw ? S_MEM_RD : S_MEM_WR;
            // MemReady is tested first so a late completion beats the timeout.
            S_MEM_RD: begin
                if (MemReady)                   state_nxt = S_WB_MEM;
                else if (wait_cnt == WAIT_LAST) state_nxt = S_FAULT;
            end
            S_MEM_WR: begin
                if (MemReady) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_FAULT;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wait_cnt    <= '0;
            RetireCount <= '0;
        end else begin
            if ((state == S_MEM_RD || state == S_MEM_WR) && !MemReady)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (retire)
                RetireCount <= RetireCount + CNT_W'(1);
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        PCSrc    = 2'b00;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        RegA     = 1'b0;
        RegB     = 1'b0;
        ALUOp    = 4'b0000;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        Illegal  = 1'b0;
        if (Reset) begin
            case (state)
                S_FETCH: begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
                S_DECODE: Illegal = !((is_r && r_ok) || is_addi || is_lw || is_sw || is_beq || is_j);
                S_EXEC_R: begin
                    ALUOp = alu_r;
                    RegA  = is_shift;
                    RegB  = is_shift;
                end
                S_EXEC_I, S_MEM_ADDR: ALUSrc = 1'b1;
                // Write-back keeps the execute-stage ALU controls so the result stays stable.
                S_WB_ALU: begin
                    RegWrite = 1'b1;
                    RegDst   = is_r;
                    if (is_r) begin
                        ALUOp = alu_r;
                        RegA  = is_shift;
                        RegB  = is_shift;
                    end else begin
                        ALUSrc = 1'b1;
                    end
                end
                S_MEM_RD: begin
                    ALUSrc  = 1'b1;
                    MemRead = 1'b1;
                end
                S_MEM_WR: begin
                    ALUSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_WB_MEM: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_BRANCH: begin
                    ALUOp   = 4'b0001;
                    PCSrc   = 2'b01;
                    PCWrite = Zero;
                end
                S_JUMP: begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign State = state;
    assign Fault = (state == S_FAULT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class, memory
// wait and timeout paths, and reset behaviour, against hand-computed expectations.
module tb_multicycle_controller;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic        IRWrite;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrc;
    logic        RegA;
    logic        RegB;
    logic [3:0]  ALUOp;
    logic        MemRead;
    logic        MemWrite;
    logic        MemtoReg;
    logic [3:0]  State;
    logic        Illegal;
    logic        Fault;
    logic [31:0] RetireCount;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int cyc0;
    int n;
    logic [3:0] exp_q[$];
    logic [3:0] exp_st;

    multicycle_controller #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .Clock(Clock), .Reset(Reset), .op(op), .func(func), .Zero(Zero),
        .MemReady(MemReady), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .RegA(RegA),
        .RegB(RegB), .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .State(State), .Illegal(Illegal), .Fault(Fault),
        .RetireCount(RetireCount)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [16:0] strobes();
        return {PCWrite, PCSrc, IRWrite, RegDst, RegWrite, ALUSrc, RegA, RegB,
                ALUOp, MemRead, MemWrite, MemtoReg, Illegal};
    endfunction

    initial begin
        Reset = 1'b0; op = 6'b000000; func = 6'b100000; Zero = 1'b0; MemReady = 1'b0;
        tick(); tick();
        check("rst_state", 32'(State), 32'd0);
        check("rst_retire", RetireCount, 32'd0);
        check("rst_fault", 32'(Fault), 32'd0);
        check("rst_strobes", 32'(strobes()), 32'd0);

        // R-type add: FETCH, DECODE, EXEC_R, WB_ALU, FETCH
        Reset = 1'b1;
        #1;
        check("fetch_irwrite", 32'(IRWrite), 32'd1);
        check("fetch_pcwrite", 32'(PCWrite), 32'd1);
        check("fetch_pcsrc", 32'(PCSrc), 32'd0);
        exp_q = {4'd0, 4'd1, 4'd2, 4'd7, 4'd0};
        while (exp_q.size() > 0) begin
            exp_st = exp_q.pop_front();
            check("add_state", 32'(State), 32'(exp_st));
            check("add_regwrite", 32'(RegWrite), 32'(exp_st == 4'd7));
            check("add_regdst", 32'(RegDst), 32'(exp_st == 4'd7));
            if (exp_q.size() > 0) tick();
        end
        check("add_retire", RetireCount, 32'd1);

        // sll selects shamt/rt sources
        func = 6'b000000;
        tick(); tick();
        check("sll_state", 32'(State), 32'd2);
        check("sll_aluop", 32'(ALUOp), 32'b1000);
        check("sll_rega_regb", 32'({RegA, RegB}), 32'b11);
        tick(); tick();
        check("sll_retire", RetireCount, 32'd2);

        // lw with MemReady on the third MEM_RD cycle
        op = 6'b100011; cyc0 = cyc;
        tick(); tick();
        check("lw_addr_state", 32'(State), 32'd4);
        check("lw_addr_alusrc", 32'(ALUSrc), 32'd1);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) MemReady = 1'b1;
            #1;
            if (State == 4'd5 && MemRead) n++;
        end
        check("lw_memread_cycles", 32'(n), 32'd3);
        tick();
        MemReady = 1'b0;
        check("lw_wbmem_state", 32'(State), 32'd8);
        check("lw_wbmem_ctl", 32'({MemtoReg, RegWrite, RegDst, MemRead}), 32'b1100);
        tick();
        check("lw_back_fetch", 32'(State), 32'd0);
        check("lw_latency", 32'(cyc - cyc0), 32'd7);
        check("lw_retire", RetireCount, 32'd3);

        // beq taken and not taken
        op = 6'b000100; Zero = 1'b1;
        tick(); tick();
        check("beq1_state", 32'(State), 32'd9);
        check("beq1_pc", 32'({PCWrite, PCSrc}), 32'b101);
        check("beq1_aluop", 32'(ALUOp), 32'b0001);
        tick();
        check("beq1_retire", RetireCount, 32'd4);
        Zero = 1'b0;
        tick(); tick();
        check("beq0_pc", 32'({PCWrite, PCSrc}), 32'b001);
        tick();
        check("beq0_retire", RetireCount, 32'd5);

        // j
        op = 6'b000010;
        tick(); tick();
        check("j_state", 32'(State), 32'd10);
        check("j_pc", 32'({PCWrite, PCSrc}), 32'b110);
        tick();
        check("j_retire", RetireCount, 32'd6);

        // addi writes rt
        op = 6'b001000;
        tick(); tick();
        check("addi_exec", 32'({State, ALUSrc, ALUOp}), 32'({4'd3, 1'b1, 4'b0000}));
        tick();
        check("addi_wb", 32'({State, RegWrite, RegDst}), 32'({4'd7, 1'b1, 1'b0}));
        tick();
        check("addi_retire", RetireCount, 32'd7);

        // illegal opcode and illegal R-type func
        op = 6'b111111;
        tick();
        check("ill_op_pulse", 32'({State, Illegal, RegWrite}), 32'({4'd1, 1'b1, 1'b0}));
        tick();
        check("ill_op_fetch", 32'({State, Illegal}), 32'({4'd0, 1'b0}));
        check("ill_op_retire", RetireCount, 32'd7);
        op = 6'b000000; func = 6'b111111;
        tick();
        check("ill_func_pulse", 32'(Illegal), 32'd1);
        tick();
        check("ill_func_fetch", 32'(State), 32'd0);

        // sw timeout into FAULT
        op = 6'b101011; MemReady = 1'b0;
        tick(); tick(); tick();
        n = 0;
        while (State == 4'd6 && n < 40) begin
            if (MemWrite) n++;
            tick();
        end
        check("sw_wr_cycles", 32'(n), 32'd16);
        check("sw_fault_state", 32'(State), 32'd15);
        check("sw_fault_flag", 32'(Fault), 32'd1);
        check("sw_fault_retire", RetireCount, 32'd7);
        MemReady = 1'b1;
        tick(); tick();
        check("fault_sticky", 32'({State, Fault}), 32'({4'd15, 1'b1}));
        check("fault_strobes", 32'(strobes()), 32'd0);
        MemReady = 1'b0; Reset = 1'b0;
        tick();
        check("fault_clear", 32'({State, Fault}), 32'd0);
        check("fault_clear_retire", RetireCount, 32'd0);

        // reset during EXEC_R abandons the instruction
        Reset = 1'b1; op = 6'b000000; func = 6'b100010;
        tick(); tick();
        check("mid_exec_state", 32'(State), 32'd2);
        check("mid_exec_aluop", 32'(ALUOp), 32'b0001);
        Reset = 1'b0;
        #1;
        check("mid_rst_strobes", 32'(strobes()), 32'd0);
        tick();
        check("mid_rst_state", 32'(State), 32'd0);
        check("mid_rst_fetch_strobes", 32'(strobes()), 32'd0);
        check("mid_rst_retire", RetireCount, 32'd0);

        // sw ready on first MEM_WR cycle
        Reset = 1'b1; op = 6'b101011; MemReady = 1'b1; cyc0 = cyc;
        tick(); tick(); tick();
        check("sw_fast_state", 32'({State, MemWrite}), 32'({4'd6, 1'b1}));
        tick();
        check("sw_fast_latency", 32'(cyc - cyc0), 32'd4);
        check("sw_fast_retire", RetireCount, 32'd1);

        // MemReady arriving on the timeout cycle wins
        MemReady = 1'b0;
        tick(); tick(); tick();
        repeat (15) tick();
        check("sw_last_state", 32'(State), 32'd6);
        MemReady = 1'b1;
        tick();
        check("sw_race_state", 32'(State), 32'd0);
        check("sw_race_retire", RetireCount, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle FSM that sequences the 32-bit MIPS-subset datapath: one instruction over 3–5+ states instead of one cycle.
- Drives the same control strobes as the single-cycle controller, plus PCWrite, IRWrite, a 2-bit PCSrc and a data-memory ready handshake with timeout.
- Sits beside the datapath. Its op/func/Zero inputs come from the instruction register and the main ALU.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in a memory state waiting for MemReady before a fault.
- CNT_W, 32: width of the RetireCount counter.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-low reset; sampled on the rising edge of Clock.
- op  in  6  IR[31:26].
- func  in  6  IR[5:0].
- Zero  in  1  main ALU zero flag.
- MemReady  in  1  data memory has completed the current read or write.
- PCWrite  out  1  PC register load enable.
- PCSrc  out  2  PC mux select: 00 = PC+4, 01 = branch target, 10 = jump target.
- IRWrite  out  1  instruction register load enable.
- RegDst  out  1  1 = rd, 0 = rt.
- RegWrite  out  1  register file write enable.
- ALUSrc  out  1  1 = sign-extended immediate, 0 = ReadData2.
- RegA  out  1  RA mux select; 1 = rt as shift source.
- RegB  out  1  RB mux select; 1 = shamt.
- ALUOp  out  4  ALU32Bit control code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt, 1000 sll, 1001 srl.
- MemRead  out  1  data memory read strobe.
- MemWrite  out  1  data memory write strobe.
- MemtoReg  out  1  1 = write-back data comes from data memory.
- State  out  4  current state encoding, for debug.
- Illegal  out  1  one-cycle pulse when an unsupported op/func is decoded.
- Fault  out  1  sticky memory-timeout flag.
- RetireCount  out  CNT_W  count of completed instructions.

Behaviour:
- Supported instructions:
  - R-type (op 000000) with func add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010.
  - lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_ALU 7, WB_MEM 8, BRANCH 9, JUMP 10, FAULT 15.
- Outputs are combinational from State, op and func. Any strobe not listed for a state is 0 in that state.
- FETCH: IRWrite=1, PCWrite=1, PCSrc=00. Next state DECODE.
- DECODE dispatch:
  - R-type → EXEC_R; addi → EXEC_I; lw or sw → MEM_ADDR; beq → BRANCH; j → JUMP.
  - Anything else: Illegal=1 for this cycle, next state FETCH; RetireCount does not increment.
- EXEC_R: ALUOp from func, ALUSrc=0. For sll/srl, RegA=1 and RegB=1. Next state WB_ALU.
- EXEC_I: ALUOp=0000, ALUSrc=1. Next state WB_ALU.
- WB_ALU:
  - ALU controls held at their EXEC values; RegWrite=1, MemtoReg=0.
  - RegDst=1 for R-type, 0 for addi.
  - Next state FETCH; retire.
- MEM_ADDR: ALUOp=0000, ALUSrc=1. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD / MEM_WR:
  - Address controls held; MemRead=1 (MEM_RD) or MemWrite=1 (MEM_WR).
  - Wait counter is cleared on entry and increments each cycle MemReady=0.
  - MemReady=1, including on the first cycle: lw → WB_MEM; sw → FETCH and retire.
  - Counter reaches MEM_TIMEOUT-1 with MemReady=0: → FAULT.
  - MemReady wins if it rises in the same cycle as the timeout.
- WB_MEM: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH; retire.
- BRANCH:
  - ALUOp=0001, ALUSrc=0, PCSrc=01, PCWrite=Zero.
  - Next state FETCH; retire whether or not the branch is taken.
- JUMP: PCSrc=10, PCWrite=1. Next state FETCH; retire.
- FAULT: all strobes 0, Fault=1. Stays in FAULT until reset.
- Latency in cycles:
  - R-type and addi: 4.
  - beq and j: 3.
  - sw: 4 + extra wait cycles.
  - lw: 5 + extra wait cycles.
- RetireCount wraps modulo 2^CNT_W.
- Reset (Reset=0 at a Clock edge):
  - Next state FETCH; wait counter 0; Fault 0; RetireCount 0.
  - While Reset=0, every strobe is forced to 0, including PCWrite and IRWrite.
  - Reset mid-instruction abandons that instruction with no register or memory write, and it is not counted.

Test Plan:
- Reset high, op=000000, func=100000 → states 0,1,2,7,0. RegWrite=1 and RegDst=1 only in state 7; RetireCount=1.
- lw with MemReady asserted on the 3rd MEM_RD cycle → MemRead=1 for exactly 3 cycles, then WB_MEM with MemtoReg=1. Total 7 cycles.
- sw with MemReady held 0, MEM_TIMEOUT=16 → FAULT after 16 MEM_WR cycles; Fault=1 sticky; RetireCount unchanged. Reset=0 clears it.
- beq with Zero=1 → PCWrite=1 and PCSrc=01 in BRANCH. Repeat with Zero=0 → PCWrite=0. RetireCount +1 each time.
- op=111111 → Illegal pulses for exactly 1 cycle in DECODE, returns to FETCH, no RegWrite, RetireCount unchanged.
- Reset=0 asserted during EXEC_R → next state FETCH, all strobes 0 while Reset=0, RetireCount=0.
